// File: rtl/score_text_ctrl.sv
// ---------------------------------------------------------------------------
// score_text_ctrl
//
// Converts two binary scores (Tom and Jerry, 0..127, shown saturated at 99)
// into decimal digits by repeated subtraction of ten, one step per cycle.
// The results are committed to the display digit registers in one cycle.
// A character-cell lookup then renders a small text screen from them.
//
// A request that arrives while a conversion is running is parked in a
// single pending slot. A later request overwrites it, so the last one wins.
// The parked request starts straight after the current commit.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        synchronous active-low reset
//   score_valid  request to load new scores
//   score_tom    Tom score, binary (7 bits)
//   score_jerry  Jerry score, binary (7 bits)
//   score_ready  high in IDLE with no pending request
//   busy         inverse of score_ready
//   update_done  one-cycle pulse in the cycle the display digits are loaded
//   char_xy      text cell address: [11:8] row, [7:0] column
//   char_code    registered ASCII code of the addressed cell
// ---------------------------------------------------------------------------
module score_text_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        score_valid,
    input  logic [6:0]  score_tom,
    input  logic [6:0]  score_jerry,
    output logic        score_ready,
    output logic        busy,
    output logic        update_done,
    input  logic [11:0] char_xy,
    output logic [6:0]  char_code
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONV_TOM   = 2'd1,
        CONV_JERRY = 2'd2,
        COMMIT     = 2'd3
    } state_t;

    state_t state;
    state_t stateNext;

    // Working registers: the remainder still to be split into tens, and
    // the digits accumulated so far for each player.
    logic [6:0] remTom;
    logic [6:0] remJerry;
    logic [3:0] tensTom;
    logic [3:0] onesTom;
    logic [3:0] tensJerry;
    logic [3:0] onesJerry;

    // Single pending slot. It holds raw input values; saturation happens
    // when the slot is launched.
    logic       pendValid;
    logic [6:0] pendTom;
    logic [6:0] pendJerry;

    // Display digit registers. They are written only in COMMIT.
    logic [3:0] dispTomTens;
    logic [3:0] dispTomOnes;
    logic [3:0] dispJerryTens;
    logic [3:0] dispJerryOnes;

    // Launch control: which score pair (if any) starts a conversion now.
    logic       launch;
    logic [6:0] launchTom;
    logic [6:0] launchJerry;

    logic       tomDone;
    logic       jerryDone;

    logic [6:0] cellCode;

    function automatic logic [6:0] saturate(input logic [6:0] s);
        return (s > 7'd99) ? 7'd99 : s;
    endfunction

    // A zero tens digit is rendered as a blank, so single-digit scores
    // appear right-aligned.
    function automatic logic [6:0] tensCode(input logic [3:0] d);
        return (d == 4'd0) ? 7'h20 : (7'h30 + {3'b000, d});
    endfunction

    function automatic logic [6:0] onesCode(input logic [3:0] d);
        return 7'h30 + {3'b000, d};
    endfunction

    // A player's conversion is finished once the remainder is a single
    // digit. That remainder becomes the ones digit.
    assign tomDone   = (remTom < 7'd10);
    assign jerryDone = (remJerry < 7'd10);

    // Decide whether a new conversion starts this cycle and with what values.
    // In COMMIT, a request arriving in the same cycle is newer than anything
    // already in the slot, so it takes precedence and chains on directly.
    // IDLE also drains the slot for robustness, even though the slot is
    // always empty when the FSM reaches IDLE.
    always_comb begin
        launch      = 1'b0;
        launchTom   = score_tom;
        launchJerry = score_jerry;
        if (state == IDLE || state == COMMIT) begin
            if (score_valid) begin
                launch = 1'b1;
            end else if (pendValid) begin
                launch      = 1'b1;
                launchTom   = pendTom;
                launchJerry = pendJerry;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic. Each conversion state lasts tens+1 cycles: one cycle
    // per subtraction of ten, plus the final cycle that captures the ones digit.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:       if (launch)    stateNext = CONV_TOM;
            CONV_TOM:   if (tomDone)   stateNext = CONV_JERRY;
            CONV_JERRY: if (jerryDone) stateNext = COMMIT;
            COMMIT:     stateNext = launch ? CONV_TOM : IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    // Status outputs depend only on the state and the slot (Moore outputs).
    always_comb begin
        score_ready = (state == IDLE) && !pendValid;
        busy        = !score_ready;
        update_done = (state == COMMIT);
    end

    // Conversion datapath: load on launch, then subtract ten per cycle in
    // the state of the player being converted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remTom    <= 7'd0;
            remJerry  <= 7'd0;
            tensTom   <= 4'd0;
            onesTom   <= 4'd0;
            tensJerry <= 4'd0;
            onesJerry <= 4'd0;
        end else if (launch) begin
            remTom    <= saturate(launchTom);
            remJerry  <= saturate(launchJerry);
            tensTom   <= 4'd0;
            onesTom   <= 4'd0;
            tensJerry <= 4'd0;
            onesJerry <= 4'd0;
        end else begin
            case (state)
                CONV_TOM: begin
                    if (!tomDone) begin
                        remTom  <= remTom - 7'd10;
                        tensTom <= tensTom + 4'd1;
                    end else begin
                        onesTom <= remTom[3:0];
                    end
                end
                CONV_JERRY: begin
                    if (!jerryDone) begin
                        remJerry  <= remJerry - 7'd10;
                        tensJerry <= tensJerry + 4'd1;
                    end else begin
                        onesJerry <= remJerry[3:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pending slot. Requests seen while converting are parked here, and the
    // latest one overwrites any earlier one. In IDLE and COMMIT the slot is
    // either launched or superseded by the request launching this cycle, so
    // it is emptied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pendValid <= 1'b0;
            pendTom   <= 7'd0;
            pendJerry <= 7'd0;
        end else if (state == IDLE || state == COMMIT) begin
            pendValid <= 1'b0;
        end else if (score_valid) begin
            pendValid <= 1'b1;
            pendTom   <= score_tom;
            pendJerry <= score_jerry;
        end
    end

    // Display digits are loaded all at once in COMMIT, so the text screen
    // never shows a half-converted score.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dispTomTens   <= 4'd0;
            dispTomOnes   <= 4'd0;
            dispJerryTens <= 4'd0;
            dispJerryOnes <= 4'd0;
        end else if (state == COMMIT) begin
            dispTomTens   <= tensTom;
            dispTomOnes   <= onesTom;
            dispJerryTens <= tensJerry;
            dispJerryOnes <= onesJerry;
        end
    end

    // Text screen layout. Fixed labels are spelled out as ASCII codes.
    // Every cell that is not listed reads as a space.
    always_comb begin
        cellCode = 7'h20;
        case (char_xy[11:8])
            4'd0: begin
                case (char_xy[7:0])
                    8'd0: cellCode = 7'h73;   // s
                    8'd1: cellCode = 7'h63;   // c
                    8'd2: cellCode = 7'h6f;   // o
                    8'd3: cellCode = 7'h72;   // r
                    8'd4: cellCode = 7'h65;   // e
                    default: cellCode = 7'h20;
                endcase
            end
            4'd1: begin
                case (char_xy[7:0])
                    8'd0: cellCode = 7'h74;   // t
                    8'd1: cellCode = 7'h6f;   // o
                    8'd2: cellCode = 7'h6d;   // m
                    8'd4: cellCode = tensCode(dispTomTens);
                    8'd5: cellCode = onesCode(dispTomOnes);
                    default: cellCode = 7'h20;
                endcase
            end
            4'd2: begin
                case (char_xy[7:0])
                    8'd0: cellCode = 7'h6a;   // j
                    8'd1: cellCode = 7'h65;   // e
                    8'd2: cellCode = 7'h72;   // r
                    8'd3: cellCode = 7'h72;   // r
                    8'd4: cellCode = 7'h79;   // y
                    8'd6: cellCode = tensCode(dispJerryTens);
                    8'd7: cellCode = onesCode(dispJerryOnes);
                    default: cellCode = 7'h20;
                endcase
            end
            default: cellCode = 7'h20;
        endcase
    end

    // The lookup runs in every state and does not depend on the FSM. The
    // only link to the conversion is through the committed display digits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            char_code <= 7'h20;
        end else begin
            char_code <= cellCode;
        end
    end

endmodule

// File: tb/tb_score_text_ctrl.sv
// ---------------------------------------------------------------------------
// tb_score_text_ctrl
//
// Testbench for score_text_ctrl. A reference model tracks each request as
// a job with a known length. The length is tens(Tom)+tens(Jerry)+3 cycles,
// and the job ends with a commit of score/10 and score%10. A compare
// process checks every DUT output against this model on every cycle. The
// directed scenarios also pin the model with hand-computed constants.
// ---------------------------------------------------------------------------
module tb_score_text_ctrl;

    logic        clk;
    logic        rst_n;
    logic        score_valid;
    logic [6:0]  score_tom;
    logic [6:0]  score_jerry;
    logic        score_ready;
    logic        busy;
    logic        update_done;
    logic [11:0] char_xy;
    logic [6:0]  char_code;

    int compared;
    int mismatched;
    bit checkEn;

    score_text_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .score_valid (score_valid),
        .score_tom   (score_tom),
        .score_jerry (score_jerry),
        .score_ready (score_ready),
        .busy        (busy),
        .update_done (update_done),
        .char_xy     (char_xy),
        .char_code   (char_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Job-level model state. remain counts the cycles of the current job
    // that are still to be shown, including its commit cycle. Zero means idle.
    typedef struct packed {
        logic [7:0] remain;
        logic [6:0] jobTom;
        logic [6:0] jobJerry;
        logic       pendValid;
        logic [6:0] pendTom;
        logic [6:0] pendJerry;
        logic [6:0] dispTom;
        logic [6:0] dispJerry;
        logic [6:0] chr;
    } model_t;

    model_t mdl;

    function automatic logic [6:0] digitCode(input int value, input bit isTens);
        int d;
        d = isTens ? value / 10 : value % 10;
        if (isTens && d == 0) return 7'h20;
        return 7'(48 + d);
    endfunction

    function automatic logic [6:0] expChar(input logic [11:0] xy, input int dT, input int dJ);
        int row;
        int col;
        string s;
        byte b;
        row = int'(xy[11:8]);
        col = int'(xy[7:0]);
        if (row == 0 && col < 5) begin
            s = "score"; b = s[col]; return b[6:0];
        end
        if (row == 1 && col < 3) begin
            s = "tom"; b = s[col]; return b[6:0];
        end
        if (row == 1 && col == 4) return digitCode(dT, 1'b1);
        if (row == 1 && col == 5) return digitCode(dT, 1'b0);
        if (row == 2 && col < 5) begin
            s = "jerry"; b = s[col]; return b[6:0];
        end
        if (row == 2 && col == 6) return digitCode(dJ, 1'b1);
        if (row == 2 && col == 7) return digitCode(dJ, 1'b0);
        return 7'h20;
    endfunction

    function automatic model_t startJob(input model_t m, input int t, input int j);
        model_t n;
        int st;
        int sj;
        n  = m;
        st = (t > 99) ? 99 : t;
        sj = (j > 99) ? 99 : j;
        n.jobTom   = 7'(st);
        n.jobJerry = 7'(sj);
        n.remain   = 8'(st / 10 + sj / 10 + 3);
        return n;
    endfunction

    function automatic model_t modelNext(input model_t m, input logic rn, input logic v,
                                         input logic [6:0] t, input logic [6:0] j,
                                         input logic [11:0] xy);
        model_t n;
        n = m;
        if (!rn) begin
            n = '0;
            n.chr = 7'h20;
            return n;
        end
        n.chr = expChar(xy, int'(m.dispTom), int'(m.dispJerry));
        if (m.remain == 0) begin
            if (v) n = startJob(n, int'(t), int'(j));
        end else if (m.remain == 1) begin
            n.dispTom   = m.jobTom;
            n.dispJerry = m.jobJerry;
            n.pendValid = 1'b0;
            n.remain    = 8'd0;
            if (v) n = startJob(n, int'(t), int'(j));
            else if (m.pendValid) n = startJob(n, int'(m.pendTom), int'(m.pendJerry));
        end else begin
            n.remain = m.remain - 8'd1;
            if (v) begin
                n.pendValid = 1'b1;
                n.pendTom   = t;
                n.pendJerry = j;
            end
        end
        return n;
    endfunction

    // Advance the model on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        mdl <= modelNext(mdl, rst_n, score_valid, score_tom, score_jerry, char_xy);
    end

    task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: all outputs are checked against the model each cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_update_done", {6'd0, update_done}, {6'd0, mdl.remain == 8'd1});
            checkOutput("model_score_ready", {6'd0, score_ready},
                        {6'd0, (mdl.remain == 8'd0) && !mdl.pendValid});
            checkOutput("model_busy", {6'd0, busy},
                        {6'd0, !((mdl.remain == 8'd0) && !mdl.pendValid)});
            checkOutput("model_char_code", char_code, mdl.chr);
        end
    end

    // Drive one cycle of inputs, then return at the next falling edge.
    task automatic applyStimulus(input bit v, input logic [6:0] t, input logic [6:0] j,
                                 input logic [11:0] xy, input bit rn);
        score_valid = v;
        score_tom   = t;
        score_jerry = j;
        char_xy     = xy;
        rst_n       = rn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 7'd0, 7'd0, char_xy, 1'b1);
    endtask

    task automatic readCell(input logic [11:0] xy, input string name, input logic [6:0] exp);
        applyStimulus(1'b0, 7'd0, 7'd0, xy, 1'b1);
        checkOutput(name, char_code, exp);
    endtask

    // Accept one request and count cycles up to update_done. The accept
    // cycle is counted as cycle 0. busy must hold on every cycle in between.
    task automatic measureLatency(input logic [6:0] t, input logic [6:0] j, input int expLat);
        int n;
        applyStimulus(1'b1, t, j, char_xy, 1'b1);
        n = 1;
        while (!update_done && n < 100) begin
            checkOutput("busy_during_conv", {6'd0, busy}, 7'd1);
            applyStimulus(1'b0, 7'd0, 7'd0, char_xy, 1'b1);
            n++;
        end
        checkOutput("latency", 7'(n), 7'(expLat));
        idle(1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!score_ready && n < 200) begin
            idle(1);
            n++;
        end
        checkOutput("wait_idle", {6'd0, score_ready}, 7'd1);
    endtask

    int pulses;
    bit sawStale;
    logic [6:0] sweepExp [8];

    initial begin
        compared   = 0;
        mismatched = 0;
        checkEn    = 1'b0;

        // Reset and its release.
        applyStimulus(1'b0, 7'd0, 7'd0, 12'h105, 1'b0);
        checkEn = 1'b1;
        applyStimulus(1'b0, 7'd0, 7'd0, 12'h105, 1'b0);
        checkOutput("reset_char_code", char_code, 7'h20);
        checkOutput("reset_update_done", {6'd0, update_done}, 7'd0);
        applyStimulus(1'b0, 7'd0, 7'd0, 12'h105, 1'b1);
        checkOutput("release_ready", {6'd0, score_ready}, 7'd1);
        checkOutput("release_busy", {6'd0, busy}, 7'd0);
        checkOutput("release_ones_cell", char_code, 7'h30);
        readCell(12'h104, "release_tens_cell", 7'h20);

        // 37/12: latency (3+1)+(1+1)+1 = 7.
        measureLatency(7'd37, 7'd12, 7);
        readCell(12'h100, "row1_t", 7'h74);
        readCell(12'h104, "tom_tens_37", 7'h33);
        readCell(12'h105, "tom_ones_37", 7'h37);
        readCell(12'h204, "row2_y", 7'h79);
        readCell(12'h206, "jerry_tens_12", 7'h31);
        readCell(12'h207, "jerry_ones_12", 7'h32);

        // Saturation: 120 shows as 99, and 5 shows with a blank tens digit.
        measureLatency(7'd120, 7'd5, 12);
        readCell(12'h104, "tom_tens_99", 7'h39);
        readCell(12'h105, "tom_ones_99", 7'h39);
        readCell(12'h206, "jerry_tens_5", 7'h20);
        readCell(12'h207, "jerry_ones_5", 7'h35);

        // Pending slot: (1,1) is overwritten by (2,3) before it can start.
        applyStimulus(1'b1, 7'd40, 7'd40, 12'h105, 1'b1);
        idle(1);
        applyStimulus(1'b1, 7'd1, 7'd1, 12'h105, 1'b1);
        applyStimulus(1'b1, 7'd2, 7'd3, 12'h105, 1'b1);
        pulses   = 0;
        sawStale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 7'd0, 7'd0, 12'h105, 1'b1);
            if (update_done) pulses++;
            if (char_code == 7'h31) sawStale = 1'b1;
        end
        checkOutput("pending_pulses", 7'(pulses), 7'd2);
        checkOutput("stale_never_shown", {6'd0, sawStale}, 7'd0);
        readCell(12'h104, "tom_tens_2", 7'h20);
        readCell(12'h105, "tom_ones_2", 7'h32);
        readCell(12'h206, "jerry_tens_3", 7'h20);
        readCell(12'h207, "jerry_ones_3", 7'h33);

        // One-cycle reset during CONV_JERRY of (45,67).
        applyStimulus(1'b1, 7'd45, 7'd67, 12'h105, 1'b1);
        idle(6);
        applyStimulus(1'b0, 7'd0, 7'd0, 12'h105, 1'b0);
        applyStimulus(1'b0, 7'd0, 7'd0, 12'h105, 1'b1);
        checkOutput("after_reset_ready", {6'd0, score_ready}, 7'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 7'd0, 7'd0, 12'h105, 1'b1);
            if (update_done) pulses++;
        end
        checkOutput("after_reset_pulses", 7'(pulses), 7'd0);
        readCell(12'h104, "rst_tom_tens", 7'h20);
        readCell(12'h105, "rst_tom_ones", 7'h30);
        readCell(12'h206, "rst_jerry_tens", 7'h20);
        readCell(12'h207, "rst_jerry_ones", 7'h30);

        // Sweep row 0 during a long conversion. Each cell is read twice.
        sweepExp = '{7'h73, 7'h63, 7'h6f, 7'h72, 7'h65, 7'h20, 7'h20, 7'h20};
        applyStimulus(1'b1, 7'd88, 7'd77, 12'h000, 1'b1);
        for (int c = 0; c < 8; c++) begin
            readCell({4'h0, 8'(c)}, "row0_sweep", sweepExp[c]);
            checkOutput("row0_sweep_busy", {6'd0, busy}, 7'd1);
            readCell({4'h0, 8'(c)}, "row0_sweep_stable", sweepExp[c]);
        end
        waitIdle();

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom % 6) == 0,
                          7'($urandom_range(0, 127)),
                          7'($urandom_range(0, 127)),
                          {4'($urandom_range(0, 3)), 8'($urandom_range(0, 9))},
                          ($urandom % 500) != 0);
        end

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/score_text_ctrl.md
SCORE_TEXT_CTRL -- requirements
Module: score_text_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low.
REQ-002 Port list SHALL be:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- score_valid  input  1  request to load new scores
- score_tom  input  7  Tom score, binary
- score_jerry  input  7  Jerry score, binary
- score_ready  output  1  high when the block is in IDLE with no pending request
- busy  output  1  high while a conversion or pending request exists
- update_done  output  1  one-cycle pulse when the displayed digits change
- char_xy  input  12  text cell address: [11:8] row, [7:0] column
- char_code  output  7  ASCII code for the addressed cell, registered

Function
REQ-003 The FSM SHALL have the states IDLE, CONV_TOM, CONV_JERRY and COMMIT.
REQ-004 Accept SHALL occur when score_valid is high in IDLE: both scores are latched into working registers and the next state is CONV_TOM.
REQ-005 Input scores above 99 SHALL saturate to 99 at latch time.
REQ-006 Conversion step, one per cycle while in CONV_x:
- if remainder >= 10: remainder -= 10, tens += 1
- else: ones = remainder, advance to the next state (CONV_TOM -> CONV_JERRY -> COMMIT)
REQ-007 Each CONV_x state SHALL last tens+1 cycles for that player.
REQ-008 In COMMIT, the four working digits SHALL be copied into the display digit registers in a single cycle; update_done SHALL be high in that cycle; the next state SHALL be IDLE.
REQ-009 The display digit registers SHALL change only in COMMIT, so the display never shows a partial result.
REQ-010 Latency from accept to update_done SHALL be (tens_tom+1)+(tens_jerry+1)+1 cycles.
REQ-011 Pending slot:
- score_valid high outside IDLE SHALL store both scores into a single pending slot.
- A later request overwrites the slot (last request wins).
REQ-012 When COMMIT completes with the pending slot full:
- the next state SHALL be CONV_TOM directly, using the pending values;
- the pending slot SHALL be cleared.
REQ-013 If score_valid is high in the same cycle as COMMIT, the new values SHALL be stored as pending and processed after that COMMIT.
REQ-014 score_ready SHALL be (state==IDLE && !pending); busy SHALL be !score_ready.
REQ-015 char_code SHALL be registered, one cycle after char_xy, with this layout:
- row 0: cols 0-4 "score"
- row 1: cols 0-2 "tom"; col 4 Tom tens; col 5 Tom ones
- row 2: cols 0-4 "jerry"; col 6 Jerry tens; col 7 Jerry ones
- all other cells: 7'h20
REQ-016 Digit cells SHALL encode as 7'h30+digit, except that a tens digit of 0 SHALL encode as 7'h20 (leading blank).
REQ-017 The char_code lookup SHALL operate in every state and SHALL be independent of the FSM.

Reset
REQ-018 With rst_n low at a clock edge, the block SHALL reset as follows:
- state = IDLE, pending slot cleared, working registers 0
- all four display digits = 0
- char_code = 7'h20, update_done = 0
REQ-019 In the first cycle after rst_n is released:
- score_ready SHALL read 1 and busy SHALL read 0;
- the digit cells SHALL display as " 0".
REQ-020 Reset asserted mid-conversion SHALL discard the conversion and the pending request and SHALL NOT assert update_done.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release, char_xy=12'h105 -> char_code 7'h30 one cycle later; char_xy=12'h104 -> 7'h20; score_ready=1.
- Accept tom=37, jerry=12 -> update_done exactly 7 cycles after the accept; then rows 1/2 read "tom 37" and "jerry 12"; busy high for those 7 cycles.
- Accept tom=120, jerry=5 -> displayed "99" and " 5"; latency 10+1+1 = 12 cycles.
- During a busy conversion, send (1,1) then (2,3) -> exactly two update_done pulses; final display "tom  2", "jerry  3"; (1,1) is never displayed.
- rst_n low for one cycle during CONV_JERRY of (45,67) -> no update_done; display " 0"/" 0"; score_ready=1 after release.
- char_xy sweep over row 0 cols 0-7 -> "score" then three 7'h20, with char_code stable during an ongoing conversion.
